// File: rtl/uart_frame_tx_if.sv
// rtl/uart_frame_tx_if.sv - word-in / UART-byte-out handshake bundle for uart_frame_tx
//
// Signals:
//   din[15:0], din_valid, din_ready   word push handshake into the frame FIFO
//   tx_start, tx_byte[7:0], tx_busy   byte request to / status from the UART transmitter
//   frame_done, frame_err             one-cycle frame completion / abort pulses
//   level, busy                       FIFO occupancy and FSM-active status
// Modports:
//   master  the environment (word producer plus UART byte transmitter)
//   slave   the framer itself
interface uart_frame_tx_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [15:0]   din;
  logic          din_valid;
  logic          din_ready;
  logic          tx_start;
  logic [7:0]    tx_byte;
  logic          tx_busy;
  logic          frame_done;
  logic          frame_err;
  logic [LW-1:0] level;
  logic          busy;

  modport master (
    output din, din_valid, tx_busy,
    input  din_ready, tx_start, tx_byte, frame_done, frame_err, level, busy
  );

  modport slave (
    input  din, din_valid, tx_busy,
    output din_ready, tx_start, tx_byte, frame_done, frame_err, level, busy
  );
endinterface

// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - queues 16-bit words and sends each as a 3-byte UART frame
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   uart_frame_tx_if.slave: word push handshake, UART byte request,
//         frame_done / frame_err pulses, FIFO level and busy status
// Frame: HDR, word[15:8], word[7:0]. Each byte is offered with a one-cycle
// tx_start, then the UART must raise tx_busy within ACK_TO+1 cycles or the
// frame is abandoned with frame_err.
module uart_frame_tx #(
  parameter logic [7:0] HDR    = 8'h80,
  parameter int         DEPTH  = 4,
  parameter int         ACK_TO = 15
) (
  input  logic           clk,
  input  logic           rst,
  uart_frame_tx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(ACK_TO + 1);

  typedef enum logic [1:0] {IDLE, START, ACK, DONE} state_t;

  state_t        state, state_d;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          push, pop;

  logic [15:0]   hold_q, hold_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // Ready looks only at the registered level, so a full FIFO stays closed
  // even in a cycle where the FSM is popping.
  assign bus.din_ready = (level != LW'(DEPTH));
  assign push          = bus.din_valid && bus.din_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      hold_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      byte_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_d;
      hold_q <= hold_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      byte_q <= byte_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  // byte_d is loaded on every transition into START so tx_byte is already
  // valid in the START cycle and holds until the frame moves on.
  always_comb begin
    state_d = state;
    hold_d  = hold_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        byte_d = 8'h00;
        if (level != '0) begin
          pop     = 1'b1;
          hold_d  = mem[rd_ptr];
          idx_d   = 2'd0;
          byte_d  = HDR;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = ACK;
      end
      ACK: begin
        if (bus.tx_busy) begin
          state_d = DONE;
        end else if (cnt_q == CW'(ACK_TO)) begin
          // The held word is dropped here; IDLE only ever pops fresh words.
          err_d   = 1'b1;
          byte_d  = 8'h00;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (!bus.tx_busy) begin
          if (idx_q == 2'd2) begin
            done_d  = 1'b1;
            byte_d  = 8'h00;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            byte_d  = (idx_q == 2'd0) ? hold_q[15:8] : hold_q[7:0];
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tx_start   = (state == START);
  assign bus.tx_byte    = byte_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;
  assign bus.level      = level;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_uart_frame_tx.sv
// tb/tb_uart_frame_tx.sv - self-checking bench for uart_frame_tx
module tb_uart_frame_tx;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_frame_tx_if #(.DEPTH(DEPTH)) bus ();

  uart_frame_tx #(.HDR(8'h80), .DEPTH(DEPTH), .ACK_TO(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  cap[$];
  logic [15:0] exp_words[$];

  int cyc = 0, last_start = 0, err_gap = 0;
  int n_start = 0, n_done = 0, n_ferr = 0, stab_bad = 0, overlap = 0;
  int busy_cnt = 0;
  int mode = 0;
  int hold = 10;
  bit rand_hold = 1'b0;
  bit mon_on = 1'b0;
  logic [7:0] held_byte = 8'h00;

  // Monitor and UART byte-transmitter model, both on the falling edge.
  // mode 0: busy rises right after tx_start and lasts hold cycles
  // mode 1: busy stuck high, mode 2: busy stuck low
  always @(negedge clk) begin
    cyc++;
    if (mon_on) begin
      if (bus.tx_start) begin
        cap.push_back(bus.tx_byte);
        last_start = cyc;
        held_byte  = bus.tx_byte;
        n_start++;
      end else if (bus.busy) begin
        if (bus.tx_byte !== held_byte) stab_bad++;
      end else if (bus.tx_byte !== 8'h00) begin
        stab_bad++;
      end
      if (bus.frame_done) n_done++;
      if (bus.frame_err) begin
        n_ferr++;
        err_gap = cyc - last_start;
      end
      if (bus.frame_done && bus.frame_err) overlap++;
    end
    if (bus.tx_start === 1'b1) busy_cnt = rand_hold ? int'($urandom_range(2, 12)) : hold;
    case (mode)
      1: begin bus.tx_busy = 1'b1; busy_cnt = 0; end
      2: begin bus.tx_busy = 1'b0; busy_cnt = 0; end
      default: begin
        if (busy_cnt > 0) begin
          bus.tx_busy = 1'b1;
          busy_cnt--;
        end else begin
          bus.tx_busy = 1'b0;
        end
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic [15:0] w);
    bit ok = 1'b0;
    bit rdy;
    int guard = 0;
    bus.din       = w;
    bus.din_valid = 1'b1;
    while (!ok && guard < 2000) begin
      rdy = bus.din_ready;
      step(1);
      if (rdy) ok = 1'b1;
      guard++;
    end
    bus.din_valid = 1'b0;
    check("push_accept", 32'(ok), 1);
    if (ok) exp_words.push_back(w);
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while ((bus.busy || bus.level != '0) && guard < 5000) begin
      step(1);
      guard++;
    end
    check({tag, "_drained"}, 32'(guard < 5000), 1);
    step(2);
  endtask

  // Reference: every accepted word becomes the byte stream 80, hi, lo, in order.
  task automatic check_frames(input string tag);
    check({tag, "_nbytes"}, cap.size(), 3 * exp_words.size());
    if (cap.size() == 3 * exp_words.size()) begin
      foreach (exp_words[k]) begin
        check({tag, "_hdr"}, cap[3*k], 8'h80);
        check({tag, "_word"}, {cap[3*k+1], cap[3*k+2]}, exp_words[k]);
      end
    end
    cap.delete();
    exp_words.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, bus.tx_start, 0);
    check({tag, "_tx_byte"}, bus.tx_byte, 8'h00);
    check({tag, "_frame_done"}, bus.frame_done, 0);
    check({tag, "_frame_err"}, bus.frame_err, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_level"}, bus.level, 0);
    check({tag, "_din_ready"}, bus.din_ready, 1);
  endtask

  initial begin
    int s0, d0, e0, g;
    logic [15:0] w, w0;

    bus.din       = '0;
    bus.din_valid = 1'b0;

    // reset
    rst = 1'b1;
    step(3);
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    step(1);
    check_reset_outputs("rst_after");
    mon_on = 1'b1;

    // single word, fixed 10-cycle UART busy
    mode = 0; rand_hold = 1'b0; hold = 10;
    s0 = n_start; d0 = n_done;
    push(16'hA55A);
    check("lat_pop_cycle", bus.tx_start, 0);
    step(1);
    check("lat_start", bus.tx_start, 1);
    check("lat_hdr", bus.tx_byte, 8'h80);
    drain("single");
    check("single_starts", n_start - s0, 3);
    check("single_done", n_done - d0, 1);
    check("single_level", bus.level, 0);
    check_frames("single");

    // fill with the UART stalled; second push coincides with the first pop
    mode = 1;
    for (int i = 0; i < 5; i++) begin
      push(16'($urandom));
      if (i == 1) check("pushpop_level", bus.level, 1);
    end
    check("full_level", bus.level, 4);
    check("full_ready", bus.din_ready, 0);
    bus.din = 16'hDEAD; bus.din_valid = 1'b1;
    step(5);
    bus.din_valid = 1'b0;
    check("full_level_held", bus.level, 4);
    check("full_ready_held", bus.din_ready, 0);
    mode = 0; rand_hold = 1'b1;
    drain("fill");
    check_frames("fill");

    // ack timeout on the first of two words
    mode = 2;
    d0 = n_done; e0 = n_ferr;
    push(16'h1234);
    push(16'($urandom));
    g = 0;
    while (!bus.frame_err && g < 200) begin step(1); g++; end
    check("tmo_err_seen", bus.frame_err, 1);
    mode = 0;
    drain("tmo");
    check("tmo_gap", err_gap, 17);
    check("tmo_errs", n_ferr - e0, 1);
    check("tmo_dones", n_done - d0, 1);
    check("tmo_nbytes_total", cap.size(), 4);
    if (cap.size() > 0) begin
      check("tmo_dropped_hdr", cap[0], 8'h80);
      void'(cap.pop_front());
    end
    void'(exp_words.pop_front());
    check_frames("tmo");

    // reset during the high byte with two words still queued
    rand_hold = 1'b0; hold = 10;
    s0 = n_start; d0 = n_done; e0 = n_ferr;
    w0 = 16'($urandom);
    push(w0);
    push(16'($urandom));
    push(16'($urandom));
    g = 0;
    while (n_start - s0 < 2 && g < 500) begin step(1); g++; end
    check("mid_starts", n_start - s0, 2);
    check("mid_level", bus.level, 2);
    check("mid_byte_hi", bus.tx_byte, w0[15:8]);
    rst = 1'b1;
    step(1);
    check_reset_outputs("mid_rst_hold");
    rst = 1'b0;
    step(1);
    check_reset_outputs("mid_rst_after");
    step(60);
    check("mid_no_more_starts", n_start - s0, 2);
    check("mid_no_done", n_done - d0, 0);
    check("mid_no_err", n_ferr - e0, 0);
    check("mid_cap_bytes", cap.size(), 2);
    cap.delete();
    exp_words.delete();

    // loopback words with random UART busy lengths
    rand_hold = 1'b1;
    push(16'h0000);
    push(16'hFFFF);
    push(16'h8080);
    drain("loop");
    check_frames("loop");

    // random words with random gaps
    for (int i = 0; i < 20; i++) begin
      w = 16'($urandom);
      push(w);
      step(int'($urandom_range(0, 3)));
    end
    drain("rand");
    check_frames("rand");

    check("byte_stability", stab_bad, 0);
    check("done_err_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_frame_tx.md
UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 Parameter HDR, default 8'h80: header byte sent first in every frame.
REQ-002 Parameter DEPTH, default 4: word FIFO depth; power of two, at least 2.
REQ-003 Parameter ACK_TO, default 15: maximum cycles to wait for tx_busy to rise after a tx_start pulse.
REQ-004 Reset is rst, synchronous, active-high; clock is clk.
REQ-005 clk  input  1  clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 din  input  16  word to send.
REQ-008 din_valid  input  1  din is presented.
REQ-009 din_ready  output  1  FIFO can accept a word.
REQ-010 tx_start  output  1  one-cycle request to the UART byte transmitter.
REQ-011 tx_byte  output  8  byte offered to the UART.
REQ-012 tx_busy  input  1  UART is-transmitting flag.
REQ-013 frame_done  output  1  one-cycle pulse when a full frame has been sent.
REQ-014 frame_err  output  1  one-cycle pulse when a frame is aborted on ack timeout.
REQ-015 level  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-016 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-017 Frame format: HDR, then din[15:8], then din[7:0]; exactly three bytes.
REQ-018 Word accept: a word is accepted on a clk edge where din_valid=1 and din_ready=1.
REQ-019 din_ready = (level != DEPTH); it is combinational from registered level and does not depend on a same-cycle pop.
REQ-020 FIFO order: first-in first-out; push and pop in the same cycle leave level unchanged.
REQ-021 FSM states and transitions:
- IDLE: if level>0, pop the head word into a 16-bit holding register, set byte index to 0, go to START.
- START: drive tx_start=1 for exactly one cycle, go to ACK.
- ACK: wait for tx_busy=1, then go to DONE. If tx_busy is still 0 after ACK_TO cycles in ACK, pulse frame_err, drop the rest of the frame, go to IDLE.
- DONE: wait for tx_busy=0. If index<2, increment index and go to START. If index==2, pulse frame_done and go to IDLE.
REQ-022 tx_byte selection: index 0 drives HDR, index 1 the held high byte, index 2 the held low byte.
- tx_byte is registered and stable from the START cycle through the DONE exit.
- tx_byte is 8'h00 in IDLE.
REQ-023 Minimum latency: with an empty FIFO, tx_start rises 2 cycles after the accepting edge (1 cycle IDLE pop, then START).
REQ-024 Back-to-back frames: after a frame_done, the next frame starts with no extra gap: IDLE pops on the following cycle.
REQ-025 The ACK timeout counter is cleared on entry to ACK; its width holds ACK_TO.
REQ-026 A popped word is never re-sent after frame_err.
REQ-027 tx_busy seen high in IDLE or START is ignored.
REQ-028 frame_done and frame_err are never high in the same cycle.

Reset
REQ-029 When rst=1 at a clk edge: FSM goes to IDLE, FIFO empties, index=0, timeout counter=0.
REQ-030 While rst=1 and on the edge after it: tx_start=0, tx_byte=8'h00, frame_done=0, frame_err=0, busy=0, level=0, din_ready=1.
REQ-031 Reset mid-frame abandons the frame with no completion or error pulse.
REQ-032 Reset mid-frame discards all FIFO contents.

Verification
REQ-033 Single word: push 16'hA55A with a UART model (busy 1 cycle after start, held 10 cycles) -> tx_byte sequence 80, A5, 5A; three tx_start pulses; one frame_done; level returns to 0.
REQ-034 Fill: push 5 words with the UART stalled (tx_busy stuck 1) -> din_ready=0 while level=4; after release, frames go out in push order.
REQ-035 Timeout: tx_busy held 0 -> frame_err exactly 16 cycles after ACK entry; no further tx_start for that word; the next queued word starts with 8'h80.
REQ-036 Reset mid-frame: assert rst during the high byte with level=2 -> all outputs at reset values; queued words never transmitted.
REQ-037 Loopback: DUT into the team UART pair and the 16-bit receiver, words 16'h0000, 16'hFFFF, 16'h8080 -> receiver dout matches each word in order.
REQ-038 Simultaneous push and pop at level=1 -> level stays 1 and FIFO order is preserved.
